fp_result_serializer: RTL and testbench

FP_RESULT_SERIALIZER -- requirements
Module: fp_result_serializer

---
 rtl/fp_pkg.sv | 18 +
 rtl/fp_classify.sv | 30 +++
 rtl/fp_result_serializer.sv | 153 +++++++++++++++
 tb/tb_fp_result_serializer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision field layout, class codes and serializer state encoding.
package fp_pkg;

    localparam int FP_W  = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    typedef logic [1:0] fp_class_t;

    localparam fp_class_t CLASS_ZERO   = 2'b00;
    localparam fp_class_t CLASS_NORMAL = 2'b01;
    localparam fp_class_t CLASS_INF    = 2'b10;
    localparam fp_class_t CLASS_NAN    = 2'b11;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single-precision classifier (zero/denormal, normal, inf, NaN).
module fp_classify
    import fp_pkg::*;
(
    input  logic [FP_W-1:0] word,
    output fp_class_t       fclass
);

    logic [EXP_W-1:0] exp_s;
    logic [MAN_W-1:0] man_s;

    assign exp_s = word[MAN_W +: EXP_W];
    assign man_s = word[MAN_W-1:0];

    // Decode the exponent/mantissa fields into a class code.
    always_comb begin
        if (exp_s == {EXP_W{1'b0}}) begin
            fclass = CLASS_ZERO;
        end else if (exp_s == {EXP_W{1'b1}}) begin
            if (man_s == {MAN_W{1'b0}}) begin
                fclass = CLASS_INF;
            end else begin
                fclass = CLASS_NAN;
            end
        end else begin
            fclass = CLASS_NORMAL;
        end
    end

endmodule

// File: rtl/fp_result_serializer.sv
// Splits 32-bit FP result words into CHUNK_W chunks, LS chunk first, with a one-word pending buffer.
// Optional macro FP_CLASSIFY_EN adds a registered FP class tag on out_class.
module fp_result_serializer
    import fp_pkg::*;
#(
    parameter int CHUNK_W = 16
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [FP_W-1:0]    in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [CHUNK_W-1:0] out_data,
    output logic [1:0]         out_idx,
    output logic               out_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         out_class
);

    localparam int         NCHUNK   = FP_W / CHUNK_W;
    localparam logic [1:0] LAST_IDX = 2'(NCHUNK - 1);

    logic [0:0]      state_r, state_s;
    logic [FP_W-1:0] shift_r, shift_s;
    logic [1:0]      idx_r, idx_s;
    logic            out_valid_r, valid_s;
    logic            in_ready_r;
    logic [FP_W-1:0] pend_r, pend_s;
    logic            pend_valid_r, pend_valid_s;

    logic            in_xfer_s;
    logic            out_xfer_s;
    logic            last_s;
    logic            load_s;
    logic [FP_W-1:0] load_word_s;

    assign in_xfer_s  = in_valid && in_ready_r;
    assign out_xfer_s = out_valid_r && out_ready;
    assign last_s     = (idx_r == LAST_IDX);

    // Pick the next active word (pending has priority over the input) and update the pending buffer.
    always_comb begin
        load_s       = 1'b0;
        load_word_s  = in_data;
        pend_s       = pend_r;
        pend_valid_s = pend_valid_r;
        case (state_r)
            ST_IDLE: begin
                if (in_xfer_s) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_SEND: begin
                if (out_xfer_s && last_s) begin
                    if (pend_valid_r) begin
                        load_s       = 1'b1;
                        load_word_s  = pend_r;
                        pend_s       = in_data;
                        pend_valid_s = in_xfer_s;
                    end else begin
                        load_s = in_xfer_s;
                    end
                end else if (in_xfer_s) begin
                    pend_s       = in_data;
                    pend_valid_s = 1'b1;
                end else begin
                    pend_valid_s = pend_valid_r;
                end
            end
            default: begin
                load_s       = 1'b0;
                pend_valid_s = 1'b0;
            end
        endcase
    end

    // Active word: load a new word, shift to the next chunk, or drop out_valid after the last chunk.
    always_comb begin
        shift_s = shift_r;
        idx_s   = idx_r;
        valid_s = out_valid_r;
        if (load_s) begin
            shift_s = load_word_s;
            idx_s   = 2'd0;
            valid_s = 1'b1;
        end else if (out_xfer_s && !last_s) begin
            shift_s = shift_r >> CHUNK_W;
            idx_s   = idx_r + 2'd1;
        end else if (out_xfer_s) begin
            valid_s = 1'b0;
        end else begin
            valid_s = out_valid_r;
        end
    end

    assign state_s = valid_s ? ST_SEND : ST_IDLE;

    // State and datapath registers; reset abandons both the active and the pending word.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            shift_r      <= {FP_W{1'b0}};
            idx_r        <= 2'd0;
            out_valid_r  <= 1'b0;
            in_ready_r   <= 1'b0;
            pend_r       <= {FP_W{1'b0}};
            pend_valid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            shift_r      <= shift_s;
            idx_r        <= idx_s;
            out_valid_r  <= valid_s;
            in_ready_r   <= !pend_valid_s;
            pend_r       <= pend_s;
            pend_valid_r <= pend_valid_s;
        end
    end

`ifdef FP_CLASSIFY_EN
    fp_class_t load_class_s;
    fp_class_t class_r;

    fp_classify u_classify (
        .word   (load_word_s),
        .fclass (load_class_s)
    );

    // Class tag follows the word into the active register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            class_r <= CLASS_ZERO;
        end else if (load_s) begin
            class_r <= load_class_s;
        end else begin
            class_r <= class_r;
        end
    end

    assign out_class = class_r;
`else
    assign out_class = CLASS_ZERO;
`endif

    assign in_ready  = in_ready_r;
    assign out_data  = shift_r[CHUNK_W-1:0];
    assign out_idx   = idx_r;
    assign out_last  = out_valid_r && last_s;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_fp_result_serializer.sv
// Bench for fp_result_serializer: two instances (CHUNK_W 16 and 8), directed tables, corner sequences, random traffic.
module tb_fp_result_serializer;

    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b1;
    logic [31:0] in_data  [2];
    logic        in_valid [2];
    logic        out_ready[2];

    logic        ir0, ov0, ol0, ir1, ov1, ol1;
    logic [1:0]  idx0, cls0, idx1, cls1;
    logic [15:0] od0;
    logic [7:0]  od1;

    int vectors     = 0;
    int miscompares = 0;

    // reference model: per-instance FIFO of accepted words plus the chunk index within the head word
    logic [31:0] mq[2][64];
    int          head[2];
    int          tail[2];
    int          cidx[2];
    logic        rst_prev[2];

    always #10 CLOCK_50 = ~CLOCK_50;

    fp_result_serializer #(.CHUNK_W(16)) dut16 (
        .CLOCK_50 (CLOCK_50), .reset (reset),
        .in_data (in_data[0]), .in_valid (in_valid[0]), .in_ready (ir0),
        .out_data (od0), .out_idx (idx0), .out_last (ol0), .out_valid (ov0),
        .out_ready (out_ready[0]), .out_class (cls0)
    );

    fp_result_serializer #(.CHUNK_W(8)) dut8 (
        .CLOCK_50 (CLOCK_50), .reset (reset),
        .in_data (in_data[1]), .in_valid (in_valid[1]), .in_ready (ir1),
        .out_data (od1), .out_idx (idx1), .out_last (ol1), .out_valid (ov1),
        .out_ready (out_ready[1]), .out_class (cls1)
    );

    function automatic logic g_ir(input int d);
        return (d == 0) ? ir0 : ir1;
    endfunction
    function automatic logic g_ov(input int d);
        return (d == 0) ? ov0 : ov1;
    endfunction
    function automatic logic g_ol(input int d);
        return (d == 0) ? ol0 : ol1;
    endfunction
    function automatic logic [1:0] g_idx(input int d);
        return (d == 0) ? idx0 : idx1;
    endfunction
    function automatic logic [1:0] g_cls(input int d);
        return (d == 0) ? cls0 : cls1;
    endfunction
    function automatic logic [15:0] g_od(input int d);
        return (d == 0) ? od0 : {8'h00, od1};
    endfunction

    function automatic logic [1:0] ref_class(input logic [31:0] w);
`ifdef FP_CLASSIFY_EN
        int e;
        int m;
        e = int'((w >> 23) & 32'hFF);
        m = int'(w & 32'h7FFFFF);
        if (e == 0)        return 2'b00;
        else if (e != 255) return 2'b01;
        else if (m == 0)   return 2'b10;
        else               return 2'b11;
`else
        return (w == 32'h0) ? 2'b00 : 2'b00;
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic mon(input int d, input int cw, input logic rst, input logic iv,
                       input logic [31:0] idata, input logic ir, input logic [15:0] od,
                       input logic [1:0] oidx, input logic olast, input logic ov,
                       input logic ordy, input logic [1:0] ocls);
        int          n;
        logic [31:0] w;
        logic [31:0] mask;
        n    = 32 / cw;
        mask = (cw == 16) ? 32'hFFFF : 32'hFF;
        if (rst) begin
            if (rst_prev[d]) begin
                check($sformatf("d%0d_rst_valid", d), {31'h0, ov}, 32'h0);
                check($sformatf("d%0d_rst_ready", d), {31'h0, ir}, 32'h0);
                check($sformatf("d%0d_rst_idx", d), {30'h0, oidx}, 32'h0);
                check($sformatf("d%0d_rst_data", d), {16'h0, od}, 32'h0);
                check($sformatf("d%0d_rst_class", d), {30'h0, ocls}, 32'h0);
            end
            head[d]     = tail[d];
            cidx[d]     = 0;
            rst_prev[d] = 1'b1;
            return;
        end
        check($sformatf("d%0d_valid", d), {31'h0, ov}, (head[d] != tail[d]) ? 32'h1 : 32'h0);
        if (rst_prev[d])
            check($sformatf("d%0d_ready_after_rst", d), {31'h0, ir}, 32'h0);
        else
            check($sformatf("d%0d_ready", d), {31'h0, ir}, (tail[d] - head[d] < 2) ? 32'h1 : 32'h0);
        rst_prev[d] = 1'b0;
        if (ov && head[d] != tail[d]) begin
            w = mq[d][head[d] % 64];
            check($sformatf("d%0d_data", d), {16'h0, od}, (w >> (cw * cidx[d])) & mask);
            check($sformatf("d%0d_idx", d), {30'h0, oidx}, 32'(cidx[d]));
            check($sformatf("d%0d_last", d), {31'h0, olast}, (cidx[d] == n - 1) ? 32'h1 : 32'h0);
            check($sformatf("d%0d_class", d), {30'h0, ocls}, {30'h0, ref_class(w)});
            if (ordy) begin
                if (cidx[d] == n - 1) begin
                    head[d]++;
                    cidx[d] = 0;
                end else begin
                    cidx[d]++;
                end
            end
        end
        if (iv && ir) begin
            mq[d][tail[d] % 64] = idata;
            tail[d]++;
        end
    endtask

    always @(negedge CLOCK_50) begin
        mon(0, 16, reset, in_valid[0], in_data[0], ir0, od0, idx0, ol0, ov0, out_ready[0], cls0);
        mon(1, 8, reset, in_valid[1], in_data[1], ir1, {8'h00, od1}, idx1, ol1, ov1, out_ready[1], cls1);
    end

    typedef struct {
        int          d;
        logic [31:0] word;
        int          nch;
        logic [63:0] chs;
        logic [1:0]  cls;
    } vec_t;

    function automatic vec_t mk(input int d, input logic [31:0] w, input int n,
                                input logic [63:0] chs, input logic [1:0] c);
        vec_t v;
        v.d = d; v.word = w; v.nch = n; v.chs = chs; v.cls = c;
        return v;
    endfunction

    task automatic wait_accept(input int d, input string nm);
        int tmo;
        tmo = 0;
        @(negedge CLOCK_50);
        while (!g_ir(d) && tmo < 40) begin
            @(negedge CLOCK_50);
            tmo++;
        end
        check(nm, {31'h0, g_ir(d)}, 32'h1);
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic wait_drain(input int d, input string nm);
        int tmo;
        tmo = 0;
        while ((head[d] != tail[d] || g_ov(d)) && tmo < 100) begin
            @(negedge CLOCK_50);
            tmo++;
        end
        check(nm, (head[d] == tail[d] && !g_ov(d)) ? 32'h1 : 32'h0, 32'h1);
    endtask

    task automatic run_vec(input vec_t v, input int i);
        logic [1:0]  ecls;
        logic [15:0] ech;
`ifdef FP_CLASSIFY_EN
        ecls = v.cls;
`else
        ecls = 2'b00;
`endif
        @(posedge CLOCK_50);
        #1;
        in_data[v.d]   = v.word;
        in_valid[v.d]  = 1'b1;
        out_ready[v.d] = 1'b1;
        wait_accept(v.d, $sformatf("v%0d_accept", i));
        in_valid[v.d] = 1'b0;
        @(negedge CLOCK_50);
        check($sformatf("v%0d_latency", i), {31'h0, g_ov(v.d)}, 32'h1);
        for (int k = 0; k < v.nch; k++) begin
            ech = v.chs[16*k +: 16];
            check($sformatf("v%0d_chunk%0d", i, k), {16'h0, g_od(v.d)}, {16'h0, ech});
            check($sformatf("v%0d_idx%0d", i, k), {30'h0, g_idx(v.d)}, 32'(k));
            check($sformatf("v%0d_last%0d", i, k), {31'h0, g_ol(v.d)}, (k == v.nch - 1) ? 32'h1 : 32'h0);
            check($sformatf("v%0d_class%0d", i, k), {30'h0, g_cls(v.d)}, {30'h0, ecls});
            @(negedge CLOCK_50);
        end
        check($sformatf("v%0d_idle", i), {31'h0, g_ov(v.d)}, 32'h0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 8)
            0:       return 32'h0000_0000;
            1:       return 32'h7F80_0000 | ($urandom & 32'h8000_0000);
            2:       return 32'h7F80_0000 | ($urandom & 32'h807F_FFFF) | 32'h1;
            3:       return $urandom & 32'h807F_FFFF;
            default: return $urandom;
        endcase
    endfunction

    vec_t        tbl[6];
    logic [15:0] frz_d;
    logic [1:0]  frz_i;
    logic [31:0] b2b[3];

    initial begin
        for (int d = 0; d < 2; d++) begin
            in_data[d] = 32'h0; in_valid[d] = 1'b0; out_ready[d] = 1'b1;
            head[d] = 0; tail[d] = 0; cidx[d] = 0; rst_prev[d] = 1'b0;
        end
        tbl[0] = mk(0, 32'h3F80_0000, 2, 64'h0000_0000_3F80_0000, 2'b01);
        tbl[1] = mk(1, 32'h7FC0_0001, 4, 64'h007F_00C0_0000_0001, 2'b11);
        tbl[2] = mk(0, 32'h0000_0000, 2, 64'h0000_0000_0000_0000, 2'b00);
        tbl[3] = mk(0, 32'h7F80_0000, 2, 64'h0000_0000_7F80_0000, 2'b10);
        tbl[4] = mk(0, 32'hC049_0FDB, 2, 64'h0000_0000_C049_0FDB, 2'b01);
        tbl[5] = mk(1, 32'h3F80_0000, 4, 64'h003F_0080_0000_0000, 2'b01);

        repeat (3) @(posedge CLOCK_50);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

        // backpressure on the 8-bit instance: freeze after chunk 0 with a pending word
        @(posedge CLOCK_50);
        #1;
        in_data[1] = 32'h1122_3344; in_valid[1] = 1'b1; out_ready[1] = 1'b1;
        wait_accept(1, "bp_accept_a");
        in_data[1] = 32'h5566_7788;
        wait_accept(1, "bp_accept_b");
        out_ready[1] = 1'b0;
        in_data[1]   = 32'h99AA_BBCC;
        @(negedge CLOCK_50);
        check("bp_ready_full", {31'h0, ir1}, 32'h0);
        check("bp_idx", {30'h0, idx1}, 32'h1);
        frz_d = {8'h00, od1};
        frz_i = idx1;
        repeat (4) begin
            @(negedge CLOCK_50);
            check("bp_frozen_data", {24'h0, od1}, {16'h0, frz_d});
            check("bp_frozen_idx", {30'h0, idx1}, {30'h0, frz_i});
            check("bp_frozen_valid", {31'h0, ov1}, 32'h1);
            check("bp_ready_low", {31'h0, ir1}, 32'h0);
        end
        @(posedge CLOCK_50);
        #1;
        out_ready[1] = 1'b1;
        wait_accept(1, "bp_accept_c");
        in_valid[1] = 1'b0;
        wait_drain(1, "bp_drain");

        // back-to-back words on the 16-bit instance
        b2b[0] = 32'h0000_0000; b2b[1] = 32'h7F80_0000; b2b[2] = 32'hC049_0FDB;
        @(posedge CLOCK_50);
        #1;
        out_ready[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data[0]  = b2b[i];
            in_valid[0] = 1'b1;
            wait_accept(0, $sformatf("b2b_accept%0d", i));
        end
        in_valid[0] = 1'b0;
        wait_drain(0, "b2b_drain");

        // reset after chunk 0 with a pending word
        @(posedge CLOCK_50);
        #1;
        in_data[0] = 32'h1234_5678; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
        wait_accept(0, "rst_accept_a");
        in_data[0] = 32'hCAFE_F00D;
        @(negedge CLOCK_50);
        check("rst_chunk0_valid", {31'h0, ov0}, 32'h1);
        check("rst_chunk0_data", {16'h0, od0}, 32'h5678);
        @(posedge CLOCK_50);
        #1;
        in_valid[0] = 1'b0;
        reset       = 1'b1;
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        @(negedge CLOCK_50);
        check("rst_valid_next", {31'h0, ov0}, 32'h0);
        check("rst_ready_next", {31'h0, ir0}, 32'h0);
        @(negedge CLOCK_50);
        check("rst_ready_rise", {31'h0, ir0}, 32'h1);
        repeat (8) begin
            @(negedge CLOCK_50);
            check("rst_no_stale", {31'h0, ov0}, 32'h0);
        end

        // random traffic on both instances against the model
        for (int c = 0; c < 800; c++) begin
            @(posedge CLOCK_50);
            #1;
            for (int d = 0; d < 2; d++) begin
                in_valid[d]  = ($urandom % 3) != 0;
                in_data[d]   = pick();
                out_ready[d] = ($urandom % 4) != 0;
            end
        end
        @(posedge CLOCK_50);
        #1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
        end
        wait_drain(0, "rand_drain16");
        wait_drain(1, "rand_drain8");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
